// File: rtl/cla4_adder.sv
// Registered 4-bit carry-lookahead adder. Each carry is a flat sum-of-products of the
// bit generate/propagate terms, and the group P/G outputs let it serve as a wider-CLA leaf.
module cla4_pg_cell (
    input  logic a,
    input  logic b,
    output logic g,
    output logic p
);
    assign g = a & b;
    assign p = a ^ b;
endmodule

module cla4_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       in_valid,
    output logic [3:0] s,
    output logic       co,
    output logic       gp,
    output logic       gg,
    output logic       out_valid
);
    logic [3:0] g, p;
    logic [4:0] c;
    logic [3:0] s_d, s_q;
    logic       co_d, co_q;
    logic       gp_d, gp_q;
    logic       gg_d, gg_q;
    logic       out_valid_d, out_valid_q;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        cla4_pg_cell u_pg (.a(a[i]), .b(b[i]), .g(g[i]), .p(p[i]));
    end

    // Every carry is built directly from g/p/ci so no carry feeds another.
    always_comb begin
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
    end

    always_comb begin
        s_d         = s_q;
        co_d        = co_q;
        gp_d        = gp_q;
        gg_d        = gg_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            s_d  = p ^ c[3:0];
            co_d = c[4];
            gp_d = &p;
            gg_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= 4'h0;
            co_q        <= 1'b0;
            gp_q        <= 1'b0;
            gg_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            co_q        <= co_d;
            gp_q        <= gp_d;
            gg_q        <= gg_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign co        = co_q;
    assign gp        = gp_q;
    assign gg        = gg_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_cla4_adder.sv
// Bench for cla4_adder: arithmetic reference model checked every cycle, plus
// hand-computed directed expectations.
module tb_cla4_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b;
    logic       ci, in_valid;
    logic [3:0] s;
    logic       co, gp, gg, out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    cla4_adder dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .in_valid(in_valid),
        .s(s), .co(co), .gp(gp), .gg(gg), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference: plain integer addition; group propagate means a+b lands exactly on 15,
    // group generate means a+b alone already carries out.
    logic [4:0] m_sum;
    logic       m_gp, m_gg, m_ov;
    logic       chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_sum  <= 5'd0;
            m_gp   <= 1'b0;
            m_gg   <= 1'b0;
            m_ov   <= 1'b0;
            chk_en <= 1'b1;
        end else if (in_valid) begin
            m_sum <= 5'(int'(a) + int'(b) + int'(ci));
            m_gp  <= (int'(a) + int'(b)) == 15;
            m_gg  <= (int'(a) + int'(b)) > 15;
            m_ov  <= 1'b1;
        end else begin
            m_ov <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({co, s} !== m_sum || gp !== m_gp || gg !== m_gg || out_valid !== m_ov) begin
                n_bad++;
                $display("FAIL model t=%0t got co_s=%b gp=%b gg=%b ov=%b want co_s=%b gp=%b gg=%b ov=%b",
                         $time, {co, s}, gp, gg, out_valid, m_sum, m_gp, m_gg, m_ov);
            end
        end
    end

    task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic tci, input logic tv);
        a = ta; b = tb; ci = tci; in_valid = tv;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [4:0] es, input logic egp, input logic egg,
                       input logic eov);
        n_cmp++;
        if ({co, s} !== es || gp !== egp || gg !== egg || out_valid !== eov) begin
            n_bad++;
            $display("FAIL %s got co_s=%b gp=%b gg=%b ov=%b want co_s=%b gp=%b gg=%b ov=%b",
                     name, {co, s}, gp, gg, out_valid, es, egp, egg, eov);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(4'hF, 4'hF, 1'b1, 1'b1);
        drive(4'hF, 4'hF, 1'b1, 1'b1);
        lit("reset", 5'b0_0000, 0, 0, 0);
        rst = 1'b0;

        drive(4'h0, 4'h0, 0, 1); lit("0+0+0", 5'b0_0000, 0, 0, 1);
        drive(4'h3, 4'h5, 0, 1); lit("3+5+0", 5'b0_1000, 0, 0, 1);
        drive(4'h7, 4'h9, 0, 1); lit("7+9+0", 5'b1_0000, 0, 1, 1);
        drive(4'h5, 4'h5, 1, 1); lit("5+5+1", 5'b0_1011, 0, 0, 1);
        drive(4'h8, 4'h7, 1, 1); lit("8+7+1", 5'b1_0000, 1, 0, 1);
        drive(4'hF, 4'hF, 0, 1); lit("F+F+0", 5'b1_1110, 0, 1, 1);
        drive(4'hF, 4'hF, 1, 1); lit("F+F+1", 5'b1_1111, 0, 1, 1);
        drive(4'hA, 4'h5, 0, 1); lit("A+5+0", 5'b0_1111, 1, 0, 1);
        drive(4'hA, 4'h5, 1, 1); lit("A+5+1", 5'b1_0000, 1, 0, 1);

        drive(4'h3, 4'h5, 0, 1); lit("hold_load", 5'b0_1000, 0, 0, 1);
        drive(4'hF, 4'hF, 1, 0); lit("hold_1", 5'b0_1000, 0, 0, 0);
        drive(4'hF, 4'hF, 1, 0); lit("hold_2", 5'b0_1000, 0, 0, 0);

        rst = 1'b1;
        drive(4'h7, 4'h9, 0, 1); lit("rst_mid", 5'b0_0000, 0, 0, 0);
        rst = 1'b0;
        drive(4'h1, 4'h1, 0, 1); lit("after_rst", 5'b0_0010, 0, 0, 1);

        for (int i = 0; i < 512; i++)
            drive(4'(i >> 5), 4'(i >> 1), i[0], 1'b1);
        drive(4'h0, 4'h0, 0, 0);
        drive(4'h0, 4'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
